// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared op and cond_sel encodings for the sequencer and the instruction decoder
package pc_sequencer_pkg;
  localparam logic [2:0] OP_NEXT = 3'b000;
  localparam logic [2:0] OP_JUMP = 3'b001;
  localparam logic [2:0] OP_CALL = 3'b010;
  localparam logic [2:0] OP_RET  = 3'b011;
  localparam logic [2:0] OP_HOLD = 3'b100;
  localparam logic [2:0] COND_ALWAYS   = 3'b000;
  localparam logic [2:0] COND_BOOL     = 3'b001;
  localparam logic [2:0] COND_ZERO     = 3'b010;
  localparam logic [2:0] COND_CARRY    = 3'b011;
  localparam logic [2:0] COND_OVERFLOW = 3'b100;
endpackage

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses
//   push/pop (mutually exclusive, caller guarantees no push when full / pop when empty)
//   push_data in, top = most recent entry, level = valid entries, full/empty decodes
module return_stack
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W        = 6,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic                               pop,
  input  logic [PC_W-1:0]                    push_data,
  output logic [PC_W-1:0]                    top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   level,
  output logic                               full,
  output logic                               empty
);
  localparam int LW = $clog2(STACK_DEPTH + 1);
  localparam int AW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [PC_W-1:0] mem [STACK_DEPTH];
  logic [AW-1:0] wr_idx, rd_idx;
  assign wr_idx = AW'(level);
  assign rd_idx = AW'(level - LW'(1));
  assign top    = mem[rd_idx];
  assign full   = level == LW'(STACK_DEPTH);
  assign empty  = level == '0;
  // storage is unreset: level alone decides what is visible
  always_ff @(posedge clk)
    if (push) mem[wr_idx] <= push_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) level <= '0;
    else if (push) level <= level + LW'(1);
    else if (pop) level <= level - LW'(1);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with conditional jump, call/return stack and sticky stack errors
//   clk, reset (async active-low), clk_enable qualifies every state update
//   op/cond_sel/target/flag_* select the next pc; clear_err clears sticky errors
//   pc, taken (redirect happened last advance), stack_level/full/empty, err_overflow/err_underflow
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W        = 6,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_PC    = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clk_enable,
  input  logic [2:0]                       op,
  input  logic [2:0]                       cond_sel,
  input  logic [PC_W-1:0]                  target,
  input  logic                             flag_bool,
  input  logic                             flag_zero,
  input  logic                             flag_carry,
  input  logic                             flag_overflow,
  input  logic                             clear_err,
  output logic [PC_W-1:0]                  pc,
  output logic                             taken,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             err_overflow,
  output logic                             err_underflow
);
  logic cond_true, do_jump, do_call, do_ret, call_ok, ret_ok, ovf, unf, redirect;
  logic [PC_W-1:0] pc_inc, top, next_pc;
  assign cond_true = cond_sel == COND_ALWAYS   ? 1'b1 :
                     cond_sel == COND_BOOL     ? flag_bool :
                     cond_sel == COND_ZERO     ? flag_zero :
                     cond_sel == COND_CARRY    ? flag_carry :
                     cond_sel == COND_OVERFLOW ? flag_overflow : 1'b0;
  assign do_jump  = op == OP_JUMP && cond_true;
  assign do_call  = op == OP_CALL && cond_true;
  assign do_ret   = op == OP_RET && cond_true;
  assign call_ok  = do_call && !stack_full;
  assign ret_ok   = do_ret && !stack_empty;
  assign ovf      = do_call && stack_full;
  assign unf      = do_ret && stack_empty;
  assign redirect = do_jump || call_ok || ret_ok;
  assign pc_inc   = pc + PC_W'(1);
  assign next_pc  = op == OP_HOLD ? pc :
                    do_jump || call_ok ? target :
                    ret_ok ? top : pc_inc;
  return_stack #(.PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (clk_enable && call_ok),
    .pop       (clk_enable && ret_ok),
    .push_data (pc_inc),
    .top       (top),
    .level     (stack_level),
    .full      (stack_full),
    .empty     (stack_empty)
  );
  // an error raised in the same advance as clear_err wins
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc            <= PC_W'(RESET_PC);
      taken         <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (clk_enable) begin
      pc            <= next_pc;
      taken         <= redirect;
      err_overflow  <= ovf || (err_overflow && !clear_err);
      err_underflow <= unf || (err_underflow && !clear_err);
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized run against a queue-based reference model
module tb_pc_sequencer;
  localparam int PC_W = 6;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 0, clk_enable = 0, clear_err = 0;
  logic [2:0] op = 0, cond_sel = 0;
  logic [PC_W-1:0] target = 0;
  logic fb = 0, fz = 0, fc = 0, fo = 0;
  logic [PC_W-1:0] pc;
  logic taken, stack_full, stack_empty, err_overflow, err_underflow;
  logic [2:0] stack_level;
  int checks = 0, passes = 0;
  int m_pc = 0, m_taken = 0, m_ovf = 0, m_unf = 0;
  int stk[$];

  pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .op(op), .cond_sel(cond_sel),
    .target(target), .flag_bool(fb), .flag_zero(fz), .flag_carry(fc), .flag_overflow(fo),
    .clear_err(clear_err), .pc(pc), .taken(taken), .stack_level(stack_level),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic adv(input int o, input int c, input int t, input bit en, input bit clr);
    bit ct;
    int npc, ntk, eo, eu;
    op = 3'(o); cond_sel = 3'(c); target = PC_W'(t); clk_enable = en; clear_err = clr;
    case (c)
      0: ct = 1;
      1: ct = fb;
      2: ct = fz;
      3: ct = fc;
      4: ct = fo;
      default: ct = 0;
    endcase
    if (en) begin
      npc = (m_pc + 1) % 64; ntk = 0; eo = 0; eu = 0;
      if (o == 4) npc = m_pc;
      else if (o == 1 && ct) begin npc = t; ntk = 1; end
      else if (o == 2 && ct) begin
        if (stk.size() < DEPTH) begin stk.push_back((m_pc + 1) % 64); npc = t; ntk = 1; end
        else eo = 1;
      end else if (o == 3 && ct) begin
        if (stk.size() > 0) begin npc = stk.pop_back(); ntk = 1; end
        else eu = 1;
      end
      m_pc = npc; m_taken = ntk;
      m_ovf = eo | (m_ovf & int'(!clr));
      m_unf = eu | (m_unf & int'(!clr));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #12;
    checks++; if ({pc, taken, stack_level, err_overflow, err_underflow} !== 0) $display("FAIL reset state: pc=%0d taken=%0b lvl=%0d ovf=%0b unf=%0b required all 0", pc, taken, stack_level, err_overflow, err_underflow); else passes++;
    checks++; if ({stack_empty, stack_full} !== 2'b10) $display("FAIL reset decodes: empty=%0b full=%0b required 1/0", stack_empty, stack_full); else passes++;
    @(negedge clk); reset = 1;
  endtask

  task automatic test_next;
    for (int i = 1; i <= 5; i++) begin
      adv(0, 0, 0, 1, 0);
      checks++; if (pc !== PC_W'(i) || taken !== 0) $display("FAIL next step %0d: pc=%0d taken=%0b required pc=%0d taken=0", i, pc, taken, i); else passes++;
    end
    adv(1, 0, 63, 1, 0);
    adv(0, 0, 0, 1, 0);
    checks++; if (pc !== 0 || taken !== 0) $display("FAIL next wrap: pc=%0d taken=%0b required 0/0", pc, taken); else passes++;
  endtask

  task automatic test_jump;
    adv(1, 0, 10, 1, 0);
    fz = 0; adv(1, 2, 40, 1, 0);
    checks++; if (pc !== 11 || taken !== 0) $display("FAIL jump not taken: pc=%0d taken=%0b required 11/0", pc, taken); else passes++;
    fz = 1; adv(1, 2, 40, 1, 0);
    checks++; if (pc !== 40 || taken !== 1) $display("FAIL jump taken: pc=%0d taken=%0b required 40/1", pc, taken); else passes++;
    fz = 0;
  endtask

  task automatic test_call_ret;
    int exp_pc[4] = '{20, 30, 21, 3};
    int exp_lv[4] = '{1, 2, 1, 0};
    int ops[4] = '{2, 2, 3, 3};
    int tg[4] = '{20, 30, 0, 0};
    adv(1, 0, 2, 1, 0);
    for (int i = 0; i < 4; i++) begin
      adv(ops[i], 0, tg[i], 1, 0);
      checks++; if (pc !== PC_W'(exp_pc[i]) || stack_level !== 3'(exp_lv[i]) || taken !== 1) $display("FAIL call_ret step %0d: pc=%0d lvl=%0d taken=%0b required pc=%0d lvl=%0d taken=1", i, pc, stack_level, taken, exp_pc[i], exp_lv[i]); else passes++;
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 4; i++) adv(2, 0, 8 + i, 1, 0);
    checks++; if (stack_level !== 4 || stack_full !== 1 || pc !== 11) $display("FAIL fill: lvl=%0d full=%0b pc=%0d required 4/1/11", stack_level, stack_full, pc); else passes++;
    adv(2, 0, 50, 1, 0);
    checks++; if (err_overflow !== 1 || pc !== 12 || stack_level !== 4 || taken !== 0) $display("FAIL overflow: ovf=%0b pc=%0d lvl=%0d taken=%0b required 1/12/4/0", err_overflow, pc, stack_level, taken); else passes++;
    adv(0, 0, 0, 1, 1);
    checks++; if (err_overflow !== 0 || pc !== 13) $display("FAIL overflow clear: ovf=%0b pc=%0d required 0/13", err_overflow, pc); else passes++;
    adv(3, 0, 0, 1, 0);
    checks++; if (pc !== 11 || stack_level !== 3) $display("FAIL lifo top: pc=%0d lvl=%0d required 11/3", pc, stack_level); else passes++;
    for (int i = 0; i < 3; i++) adv(3, 0, 0, 1, 0);
    checks++; if (pc !== PC_W'(m_pc) || stack_empty !== 1) $display("FAIL drain: pc=%0d empty=%0b required %0d/1", pc, stack_empty, m_pc); else passes++;
  endtask

  task automatic test_underflow;
    int prev;
    prev = m_pc;
    adv(3, 0, 0, 1, 1);
    checks++; if (err_underflow !== 1 || pc !== PC_W'((prev + 1) % 64) || taken !== 0) $display("FAIL underflow set-wins: unf=%0b pc=%0d taken=%0b required 1/%0d/0", err_underflow, pc, taken, (prev + 1) % 64); else passes++;
  endtask

  task automatic test_enable;
    int held;
    held = m_pc;
    for (int i = 0; i < 3; i++) begin
      adv(1, 0, 50, 0, 1);
      checks++; if (pc !== PC_W'(held) || err_underflow !== 1 || taken !== 0) $display("FAIL enable hold %0d: pc=%0d unf=%0b taken=%0b required %0d/1/0", i, pc, err_underflow, taken, held); else passes++;
    end
    adv(0, 0, 0, 1, 1);
  endtask

  task automatic test_reset_mid;
    adv(2, 0, 33, 1, 0);
    adv(2, 0, 44, 1, 0);
    checks++; if (stack_level !== 2) $display("FAIL pre-reset level: lvl=%0d required 2", stack_level); else passes++;
    reset = 0; #1;
    checks++; if (pc !== 0 || stack_level !== 0 || taken !== 0 || stack_empty !== 1) $display("FAIL async reset: pc=%0d lvl=%0d taken=%0b empty=%0b required 0/0/0/1", pc, stack_level, taken, stack_empty); else passes++;
    m_pc = 0; m_taken = 0; m_ovf = 0; m_unf = 0; stk.delete();
    @(negedge clk); reset = 1;
    adv(3, 0, 0, 1, 0);
    checks++; if (pc !== 1 || err_underflow !== 1 || stack_level !== 0) $display("FAIL post-reset ret: pc=%0d unf=%0b lvl=%0d required 1/1/0", pc, err_underflow, stack_level); else passes++;
  endtask

  task automatic test_random;
    logic [14:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      {fb, fz, fc, fo} = 4'($urandom);
      adv(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 63)),
          $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0);
      got = {pc, taken, stack_level, stack_full, stack_empty, err_overflow, err_underflow};
      exp = {PC_W'(m_pc), 1'(m_taken), 3'(stk.size()), stk.size() == DEPTH, stk.size() == 0, 1'(m_ovf), 1'(m_unf)};
      checks++; if (got !== exp) $display("FAIL random step %0d: got %h required %h", i, got, exp); else passes++;
    end
  endtask

  initial begin
    test_reset;
    test_next;
    test_jump;
    test_call_ret;
    test_overflow;
    test_underflow;
    test_enable;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 6: program-counter width in bits.
REQ-002 Parameter STACK_DEPTH, default 4: return-stack entries, minimum 1.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 clk_enable  input  1  advance qualifier; when low, all state holds.
REQ-007 op  input  3  sequencing operation: NEXT=000, JUMP=001, CALL=010, RET=011, HOLD=100; other codes act as NEXT.
REQ-008 cond_sel  input  3  condition: 000 always, 001 bool, 010 zero, 011 carry, 100 overflow, others never.
REQ-009 target  input  PC_W  destination for JUMP and CALL.
REQ-010 flag_bool, flag_zero, flag_carry, flag_overflow  input  1 each  ALU status flags.
REQ-011 clear_err  input  1  clears the sticky error flags.
REQ-012 pc  output  PC_W  current program counter (registered).
REQ-013 taken  output  1  registered; high for the cycle after an advance that redirected the PC.
REQ-014 stack_level  output  $clog2(STACK_DEPTH+1)  number of valid return entries.
REQ-015 stack_full, stack_empty  output  1 each  combinational decodes of stack_level.
REQ-016 err_overflow, err_underflow  output  1 each  sticky CALL-when-full and RET-when-empty flags.

Function
REQ-017 An advance is a rising edge with clk_enable=1; all function rules below apply only on advances.
REQ-018 cond_true is the flag selected by cond_sel, evaluated combinationally in the advance cycle.
REQ-019 NEXT: pc <= pc+1, modulo 2^PC_W (all-ones wraps to 0); taken <= 0.
REQ-020 HOLD: pc is unchanged; taken <= 0.
REQ-021 JUMP with cond_true: pc <= target, taken <= 1. Otherwise NEXT behaviour.
REQ-022 CALL with cond_true and not full: push pc+1 (wrapped), pc <= target, level +1, taken <= 1.
REQ-023 CALL with cond_true and full: no push, pc <= pc+1, err_overflow <= 1, taken <= 0.
REQ-024 RET with cond_true and not empty: pc <= top entry, pop, level -1, taken <= 1.
REQ-025 RET with cond_true and empty: pc <= pc+1, err_underflow <= 1, taken <= 0.
REQ-026 CALL or RET with cond false: NEXT behaviour, stack unchanged, no error.
REQ-027 Latency: the new pc is visible the cycle after the advance edge; no combinational path from op or target to pc.
REQ-028 clear_err on an advance clears both error flags, except that an error raised in the same advance sets its flag (set wins).
REQ-029 clk_enable=0: pc, taken, stack contents, level, and errors all hold; clear_err is ignored.
REQ-030 The stack is LIFO; a CALL at level STACK_DEPTH-1 reaches full, and the next RET returns the most recent push.

Reset
REQ-031 Asserting reset low immediately forces pc=RESET_PC, taken=0, stack_level=0, err_overflow=0, err_underflow=0, independent of clk.
REQ-032 Reset asserted mid-operation discards all stack entries; entry storage needs no reset, and stale contents are never observable.
REQ-033 Release of reset is synchronous to clk; the first advance after release operates from RESET_PC.

Structure
REQ-034 A shared package holds the op and cond_sel encodings as named constants, used by both this block and the decoder.
REQ-035 The return stack is one sub-module, return_stack (parameters PC_W and STACK_DEPTH; push, pop, top, level, full, empty).
REQ-036 Condition select, next-PC mux, and error logic live in pc_sequencer.

Verification
REQ-037 Reset, then 5 advances of NEXT -> pc 0,1,2,3,4,5; taken stays 0; at pc=63, NEXT -> pc=0.
REQ-038 pc=10, JUMP target=40, cond_sel=010, zero=0 -> pc=11, taken=0; repeat with zero=1 -> pc=40, taken=1.
REQ-039 From pc=2: CALL 20, then CALL 30, then RET, then RET -> pc 20, 30, 21, 3; level 1, 2, 1, 0.
REQ-040 Fill the stack with 4 CALLs, then a fifth CALL -> err_overflow=1, pc=prev+1, level=4; clear_err with a NEXT -> flag 0.
REQ-041 RET when empty with clear_err=1 in the same advance -> err_underflow=1 (set wins), pc=prev+1.
REQ-042 clk_enable=0 for 3 cycles with op=JUMP -> pc holds; reset pulsed low mid-cycle after 2 CALLs -> pc=0, level=0 before the next edge.
